// File: rtl/rs232_byte_fifo_pkg.sv
// Shared definitions for the RS-232 byte FIFO: default widths and the
// state encodings of the input and output handshake FSMs.
package rs232_pkg;

  localparam int RS232_DATA_W          = 8;
  localparam int RS232_FIFO_DEPTH_LOG2 = 4;

  // Input handshake FSM: waiting for a request, or holding the acknowledge.
  typedef logic [0:0] in_state_t;
  localparam in_state_t IN_IDLE = 1'b0;
  localparam in_state_t IN_ACK  = 1'b1;

  // Output handshake FSM: loading a byte, presenting it, waiting for ack release.
  typedef logic [1:0] out_state_t;
  localparam out_state_t OUT_IDLE = 2'd0;
  localparam out_state_t OUT_REQ  = 2'd1;
  localparam out_state_t OUT_WAIT = 2'd2;

endpackage

// File: rtl/rs232_byte_fifo_if.sv
// Producer/consumer handshake bundle of the byte FIFO. The slave modport is
// the FIFO's own view; the master modport is the view of the surrounding logic.
interface rs232_byte_fifo_if
  import rs232_pkg::*;
#(
  parameter int P_WIDTH      = RS232_DATA_W,
  parameter int P_DEPTH_LOG2 = RS232_FIFO_DEPTH_LOG2
);

  logic [P_WIDTH-1:0]    in_data;
  logic                  in_req;
  logic                  in_ack;
  logic [P_WIDTH-1:0]    out_data;
  logic                  out_req;
  logic                  out_ack;
  logic [P_DEPTH_LOG2:0] count;
  logic                  full;
  logic                  empty;

  modport master (
    output in_data, in_req, out_ack,
    input  in_ack, out_data, out_req, count, full, empty
  );

  modport slave (
    input  in_data, in_req, out_ack,
    output in_ack, out_data, out_req, count, full, empty
  );

endinterface

// File: rtl/rs232_fifo_ram.sv
// Simple dual-port storage for the byte FIFO: synchronous write, registered
// read. The read register doubles as the presented output byte, so it only
// loads when a read is issued and otherwise holds its value.
module rs232_fifo_ram
  import rs232_pkg::*;
#(
  parameter int P_WIDTH      = RS232_DATA_W,
  parameter int P_DEPTH_LOG2 = RS232_FIFO_DEPTH_LOG2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_en,
  input  logic [P_DEPTH_LOG2-1:0] wr_addr,
  input  logic [P_WIDTH-1:0]      wr_data,
  input  logic                    rd_en,
  input  logic [P_DEPTH_LOG2-1:0] rd_addr,
  output logic [P_WIDTH-1:0]      rd_data
);

  localparam int DEPTH = 1 << P_DEPTH_LOG2;

  logic [P_WIDTH-1:0] mem [0:DEPTH-1];
  logic [P_WIDTH-1:0] rd_data_reg;

  // Storage write; the array itself carries no reset so it maps onto RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Registered read, held between reads so a presented byte never changes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_reg <= '0;
    end else if (rd_en) begin
      rd_data_reg <= mem[rd_addr];
    end
  end

  assign rd_data = rd_data_reg;

endmodule

// File: rtl/rs232_byte_fifo.sv
// Elastic byte buffer between the serial receiver and its consumer. Bytes
// enter on a four-phase req/ack port and leave, in order, on an identical
// port. Pointers carry one extra wrap bit so occupancy is a plain subtraction.
module rs232_byte_fifo
  import rs232_pkg::*;
#(
  parameter int P_WIDTH      = RS232_DATA_W,
  parameter int P_DEPTH_LOG2 = RS232_FIFO_DEPTH_LOG2
) (
  input logic              clk,
  input logic              rst_n,
  rs232_byte_fifo_if.slave bus
);

  localparam int DEPTH = 1 << P_DEPTH_LOG2;

  typedef logic [P_DEPTH_LOG2:0] ptr_t;

  in_state_t  in_state_reg, in_state_next;
  out_state_t out_state_reg, out_state_next;
  ptr_t       wr_ptr_reg, wr_ptr_next;
  ptr_t       rd_ptr_reg, rd_ptr_next;
  ptr_t       count_reg, count_next;
  logic       full_reg, full_next;
  logic       empty_reg, empty_next;
  logic       in_ack_reg, in_ack_next;
  logic       out_req_reg, out_req_next;
  logic       push, pop, load;

  // Transfer events of this cycle and the resulting pointers and flags.
  always_comb begin
    push        = (in_state_reg == IN_IDLE) && bus.in_req && !full_reg;
    pop         = (out_state_reg == OUT_REQ) && bus.out_ack;
    load        = (out_state_reg == OUT_IDLE) && !empty_reg;
    wr_ptr_next = wr_ptr_reg + ptr_t'(push);
    rd_ptr_next = rd_ptr_reg + ptr_t'(pop);
    count_next  = wr_ptr_next - rd_ptr_next;
    full_next   = (count_next == ptr_t'(DEPTH));
    empty_next  = (count_next == '0);
  end

  // Input handshake: acknowledge a request once the byte is stored, then
  // wait for the producer to drop its request.
  always_comb begin
    in_state_next = in_state_reg;
    in_ack_next   = in_ack_reg;
    case (in_state_reg)
      IN_IDLE: begin
        if (push) begin
          in_state_next = IN_ACK;
          in_ack_next   = 1'b1;
        end
      end
      default: begin
        if (!bus.in_req) begin
          in_state_next = IN_IDLE;
          in_ack_next   = 1'b0;
        end
      end
    endcase
  end

  // Output handshake: the RAM read issued in OUT_IDLE lands in the output
  // register on the same edge that raises out_req.
  always_comb begin
    out_state_next = out_state_reg;
    out_req_next   = out_req_reg;
    case (out_state_reg)
      OUT_IDLE: begin
        if (load) begin
          out_state_next = OUT_REQ;
          out_req_next   = 1'b1;
        end
      end
      OUT_REQ: begin
        if (bus.out_ack) begin
          out_state_next = OUT_WAIT;
          out_req_next   = 1'b0;
        end
      end
      OUT_WAIT: begin
        if (!bus.out_ack) begin
          out_state_next = OUT_IDLE;
        end
      end
      default: begin
        out_state_next = OUT_IDLE;
        out_req_next   = 1'b0;
      end
    endcase
  end

  // State, pointer and flag registers; reset discards any in-flight data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_state_reg  <= IN_IDLE;
      out_state_reg <= OUT_IDLE;
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      full_reg      <= 1'b0;
      empty_reg     <= 1'b1;
      in_ack_reg    <= 1'b0;
      out_req_reg   <= 1'b0;
    end else begin
      in_state_reg  <= in_state_next;
      out_state_reg <= out_state_next;
      wr_ptr_reg    <= wr_ptr_next;
      rd_ptr_reg    <= rd_ptr_next;
      count_reg     <= count_next;
      full_reg      <= full_next;
      empty_reg     <= empty_next;
      in_ack_reg    <= in_ack_next;
      out_req_reg   <= out_req_next;
    end
  end

  rs232_fifo_ram #(
    .P_WIDTH      (P_WIDTH),
    .P_DEPTH_LOG2 (P_DEPTH_LOG2)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (push),
    .wr_addr (wr_ptr_reg[P_DEPTH_LOG2-1:0]),
    .wr_data (bus.in_data),
    .rd_en   (load),
    .rd_addr (rd_ptr_reg[P_DEPTH_LOG2-1:0]),
    .rd_data (bus.out_data)
  );

  assign bus.in_ack  = in_ack_reg;
  assign bus.out_req = out_req_reg;
  assign bus.count   = count_reg;
  assign bus.full    = full_reg;
  assign bus.empty   = empty_reg;

endmodule
